// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares one register-file write port between EX and LSU.
// Define WB_STARVE_GUARD_EN to add the LSU starvation counter and forced-grant state.
//
// state     | meaning
// EX_PRI    | EX wins when both requesters are valid
// LSU_FORCE | LSU lost STARVE_LIMIT times in a row; LSU wins the next contested cycle
module wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [31:0] ex_rd_data_i,
    output logic        ex_ready_o,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_rd_addr_i,
    input  logic [31:0] lsu_rd_data_i,
    output logic        lsu_ready_o,
    output logic        reg_wen_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o
);

    logic ex_grant;
    logic lsu_grant;
    logic force_lsu;

    // Readies are gated by reset so nothing is accepted while the block is held.
    assign ex_grant    = rst & ex_valid_i & ~(lsu_valid_i & force_lsu);
    assign lsu_grant   = rst & lsu_valid_i & ~ex_grant;
    assign ex_ready_o  = ex_grant;
    assign lsu_ready_o = lsu_grant;

`ifdef WB_STARVE_GUARD_EN
    typedef enum logic {
        EX_PRI    = 1'b0,
        LSU_FORCE = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= EX_PRI;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        starve_d = '0;
        state_d  = state_q;
        if (lsu_valid_i && ex_grant)
            starve_d = (starve_q == 4'd15) ? starve_q : starve_q + 4'd1;
        if (state_q == EX_PRI) begin
            if (starve_d >= LIMIT)
                state_d = LSU_FORCE;
        end else begin
            // A withdrawn LSU request has nothing left to force.
            if (lsu_grant || !lsu_valid_i)
                state_d = EX_PRI;
        end
    end

    assign force_lsu = (state_q == LSU_FORCE);
`else
    assign force_lsu = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_wen_o <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else begin
            reg_wen_o <= 1'b0;
            if (ex_grant) begin
                reg_wen_o <= |ex_rd_addr_i;
                rd_addr_o <= ex_rd_addr_i;
                rd_data_o <= ex_rd_data_i;
            end else if (lsu_grant) begin
                reg_wen_o <= |lsu_rd_addr_i;
                rd_addr_o <= lsu_rd_addr_i;
                rd_data_o <= lsu_rd_data_i;
            end
        end
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive LSU losses before LSU is force-granted (legal 1..15).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ex_valid_i  input  1  EX stage write-back request.
REQ-005 ex_rd_addr_i  input  5  EX destination register.
REQ-006 ex_rd_data_i  input  32  EX result.
REQ-007 ex_ready_o  output  1  EX request accepted this cycle.
REQ-008 lsu_valid_i  input  1  load unit write-back request.
REQ-009 lsu_rd_addr_i  input  5  load destination register.
REQ-010 lsu_rd_data_i  input  32  load data.
REQ-011 lsu_ready_o  output  1  LSU request accepted this cycle.
REQ-012 reg_wen_o  output  1  register file write enable.
REQ-013 rd_addr_o  output  5  register file write address.
REQ-014 rd_data_o  output  32  register file write data.

Function
REQ-015 Block SHALL share the single register-file write port between EX and LSU requesters.
REQ-016 Handshake: a request is accepted on a cycle where valid and ready are both high; requester SHALL hold addr/data stable while valid and not ready.
REQ-017 ex_ready_o / lsu_ready_o SHALL be combinational from valids and arbiter state; at most one SHALL be high in any cycle.
REQ-018 Only EX valid -> EX granted; only LSU valid -> LSU granted; neither -> no grant, both ready low.
REQ-019 Both valid, arbiter in state EX_PRI -> EX granted.
REQ-020 Both valid, arbiter in state LSU_FORCE -> LSU granted.
REQ-021 Accepted request SHALL appear on rd_addr_o/rd_data_o with reg_wen_o=1 on the cycle after acceptance (latency 1), for exactly one cycle.
REQ-022 Cycle with no acceptance SHALL drive reg_wen_o=0 next cycle; rd_addr_o/rd_data_o SHALL hold previous values.
REQ-023 Accepted request with rd_addr=0 SHALL complete the handshake but drive reg_wen_o=0 (x0 never written).
REQ-024 Starvation counter (4 bits): +1 each cycle LSU valid and EX granted; cleared when LSU granted or LSU not valid.
REQ-025 FSM EX_PRI -> LSU_FORCE when counter reaches STARVE_LIMIT; LSU_FORCE -> EX_PRI after the LSU grant (single forced grant).
REQ-026 Counter SHALL saturate at 15, never wrap.
REQ-027 Both valid with identical rd_addr: winner written first, loser on a later cycle (loser value ends in register file).
REQ-028 Throughput: one write-back per cycle sustained whenever any requester is valid.

Reset
REQ-029 rst low SHALL asynchronously force reg_wen_o=0, rd_addr_o=0, rd_data_o=0, counter=0, FSM=EX_PRI.
REQ-030 While rst low, ex_ready_o and lsu_ready_o SHALL be 0.
REQ-031 Reset mid-operation: an accepted but not yet written request SHALL be dropped; requesters re-present after reset.
REQ-032 First acceptance possible on the first rising edge with rst high.

Configuration
REQ-033 Macro WB_STARVE_GUARD_EN defined: starvation counter and LSU_FORCE state per REQ-024..026.
REQ-034 Macro WB_STARVE_GUARD_EN undefined: no counter, no LSU_FORCE; strict EX-over-LSU priority; LSU may starve indefinitely.

Verification
REQ-035 Reset: rst low with ex_valid_i=1 -> both ready 0, reg_wen_o=0, outputs 0; release -> EX accepted on first edge.
REQ-036 Single EX: ex_valid_i=1, addr=5, data=0xDEADBEEF one cycle -> next cycle reg_wen_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF; following cycle reg_wen_o=0.
REQ-037 x0: lsu_valid_i=1, addr=0, data=0x1234 -> lsu_ready_o=1, next cycle reg_wen_o=0.
REQ-038 Starvation (macro on, STARVE_LIMIT=4): both valid continuously, EX addr=1, LSU addr=2 -> EX granted 4 cycles, LSU granted cycle 5, EX cycle 6; macro off -> LSU never granted.
REQ-039 Same address: EX addr=7 data=0xA, LSU addr=7 data=0xB same cycle -> write 0xA then 0xB on consecutive cycles.
REQ-040 Async reset mid-transfer: rst low between acceptance edge and write cycle -> reg_wen_o drops immediately, no write occurs.
